// File: rtl/ghost_mode_scheduler.sv
// Central scheduler for the four ghosts: scatter/chase schedule, frightened timing with
// end-flash, eat-combo scoring and ghost-house release order.
module ghost_mode_scheduler #(
  parameter int unsigned TICKS_PER_SEC = 60,
  parameter int unsigned SCAT_LONG_S   = 7,
  parameter int unsigned SCAT_SHORT_S  = 5,
  parameter int unsigned CHASE_S       = 20,
  parameter int unsigned FRIGHT_S      = 10,
  parameter int unsigned FLASH_S       = 5,
  parameter int unsigned INKY_DOTS     = 30,
  parameter int unsigned CLYDE_DOTS    = 60,
  parameter int unsigned IDLE_S        = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        soft_reset,
  input  logic        new_map,
  input  logic        level_start,
  input  logic        dot_eaten,
  input  logic        power_pellet,
  input  logic [3:0]  ghost_eaten,
  input  logic [3:0]  ghost_home,
  output logic [1:0]  global_mode,
  output logic [7:0]  ghost_state,
  output logic        fright_flash,
  output logic [3:0]  released,
  output logic [2:0]  round,
  output logic        score_valid,
  output logic [11:0] score_value
);

  typedef enum logic [1:0] {ModeWait = 2'd0, ModeScatter = 2'd1, ModeChase = 2'd2} mode_e;

  localparam logic [1:0]  GhNormal  = 2'd0;
  localparam logic [1:0]  GhFright  = 2'd1;
  localparam logic [1:0]  GhDead    = 2'd2;
  localparam logic [7:0]  TickLast  = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0]  ScatLongS = 8'(SCAT_LONG_S);
  localparam logic [7:0]  ScatShrtS = 8'(SCAT_SHORT_S);
  localparam logic [7:0]  ChaseS    = 8'(CHASE_S);
  localparam logic [7:0]  FrightS   = 8'(FRIGHT_S);
  localparam logic [7:0]  FlashS    = 8'(FLASH_S);
  localparam logic [7:0]  InkyDots  = 8'(INKY_DOTS);
  localparam logic [7:0]  ClydeDots = 8'(CLYDE_DOTS);
  localparam logic [11:0] IdleTicks = 12'(IDLE_S * TICKS_PER_SEC);

  mode_e       mode_q, mode_d;
  logic [2:0]  round_q, round_d;
  logic [7:0]  ph_tick_q, ph_tick_d, ph_sec_q, ph_sec_d;
  logic        fr_run_q, fr_run_d;
  logic [7:0]  fr_tick_q, fr_tick_d, fr_sec_q, fr_sec_d;
  logic [1:0]  combo_q, combo_c;
  logic [7:0]  gst_q, gst_d;
  logic [3:0]  rel_q, rel_d;
  logic [7:0]  dots_q, dots_d, dots_inc;
  logic [11:0] idle_q, idle_d, idle_inc;
  logic        flash_q, flash_d;
  logic        sv_q, sv_d;
  logic [11:0] score_q, sum_c;
  logic        pellet, fr_expire, any_fr_q, any_fr_d;
  logic [7:0]  scat_sec, rel_limit;
  logic [1:0]  rel_next;

  always_comb begin
    mode_d    = mode_q;
    round_d   = round_q;
    ph_tick_d = ph_tick_q;
    ph_sec_d  = ph_sec_q;
    fr_run_d  = fr_run_q;
    fr_tick_d = fr_tick_q;
    fr_sec_d  = fr_sec_q;
    gst_d     = gst_q;
    rel_d     = rel_q;
    dots_d    = dots_q;
    idle_d    = idle_q;
    sum_c     = '0;
    fr_expire = 1'b0;
    any_fr_q  = 1'b0;
    any_fr_d  = 1'b0;
    dots_inc  = dots_q;
    idle_inc  = idle_q;
    rel_next  = 2'd2;
    rel_limit = InkyDots;
    pellet    = power_pellet && (mode_q != ModeWait);
    combo_c   = pellet ? 2'd0 : combo_q;
    scat_sec  = (round_q < 3'd2) ? ScatLongS : ScatShrtS;

    for (int i = 0; i < 4; i++) begin
      if (gst_q[2*i +: 2] == GhFright) any_fr_q = 1'b1;
    end

    // Mode schedule; the phase timer is frozen while any ghost is frightened.
    if (mode_q == ModeWait) begin
      if (level_start) begin
        mode_d   = ModeScatter;
        rel_d[0] = 1'b1;
      end
    end else if (frame_tick && !any_fr_q && !(mode_q == ModeChase && round_q == 3'd4)) begin
      if (ph_tick_q == TickLast) begin
        ph_tick_d = '0;
        ph_sec_d  = ph_sec_q + 8'd1;
        if (mode_q == ModeScatter && ph_sec_d == scat_sec) begin
          mode_d   = ModeChase;
          ph_sec_d = '0;
          if (round_q == 3'd3) round_d = 3'd4;
        end else if (mode_q == ModeChase && ph_sec_d == ChaseS) begin
          mode_d   = ModeScatter;
          ph_sec_d = '0;
          round_d  = round_q + 3'd1;
        end
      end else begin
        ph_tick_d = ph_tick_q + 8'd1;
      end
    end

    if (pellet) begin
      fr_run_d  = 1'b1;
      fr_tick_d = '0;
      fr_sec_d  = '0;
    end else if (fr_run_q && frame_tick) begin
      if (fr_tick_q == TickLast) begin
        fr_tick_d = '0;
        fr_sec_d  = fr_sec_q + 8'd1;
        if (fr_sec_d == FrightS) begin
          fr_expire = 1'b1;
          fr_run_d  = 1'b0;
          fr_sec_d  = '0;
        end
      end else begin
        fr_tick_d = fr_tick_q + 8'd1;
      end
    end

    // Eats are judged on the pre-cycle state, lowest index first.
    for (int i = 0; i < 4; i++) begin
      case (gst_q[2*i +: 2])
        GhNormal: if (pellet && rel_q[i]) gst_d[2*i +: 2] = GhFright;
        GhFright: begin
          if (ghost_eaten[i]) begin
            gst_d[2*i +: 2] = GhDead;
            sum_c = sum_c + (12'd200 << combo_c);
            if (combo_c != 2'd3) combo_c = combo_c + 2'd1;
          end else if (fr_expire) begin
            gst_d[2*i +: 2] = GhNormal;
          end
        end
        GhDead:   if (ghost_home[i]) gst_d[2*i +: 2] = GhNormal;
        default:  gst_d[2*i +: 2] = GhNormal;
      endcase
      if (gst_d[2*i +: 2] == GhFright) any_fr_d = 1'b1;
    end

    flash_d = fr_run_d && any_fr_d && (fr_sec_d >= FlashS) && ((fr_tick_d % 8'd20) < 8'd10);

    if (mode_q != ModeWait) begin
      if (!rel_q[1]) begin
        rel_d[1] = 1'b1;
        dots_d   = '0;
        idle_d   = '0;
      end else if (!rel_q[2] || !rel_q[3]) begin
        if (rel_q[2]) begin
          rel_next  = 2'd3;
          rel_limit = ClydeDots;
        end
        if (dot_eaten) begin
          dots_inc = (dots_q == 8'hFF) ? dots_q : dots_q + 8'd1;
          idle_inc = '0;
        end else if (frame_tick) begin
          idle_inc = (idle_q == 12'hFFF) ? idle_q : idle_q + 12'd1;
        end
        if (dots_inc >= rel_limit || idle_inc >= IdleTicks) begin
          rel_d[rel_next] = 1'b1;
          dots_d          = '0;
          idle_d          = '0;
        end else begin
          dots_d = dots_inc;
          idle_d = idle_inc;
        end
      end
    end

    sv_d = (sum_c != 12'd0);

    if (soft_reset || new_map) begin
      mode_d    = ModeWait;
      round_d   = '0;
      ph_tick_d = '0;
      ph_sec_d  = '0;
      fr_run_d  = 1'b0;
      fr_tick_d = '0;
      fr_sec_d  = '0;
      combo_c   = '0;
      gst_d     = '0;
      rel_d     = '0;
      dots_d    = '0;
      idle_d    = '0;
      flash_d   = 1'b0;
      sv_d      = 1'b0;
      sum_c     = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mode_q    <= ModeWait;
      round_q   <= '0;
      ph_tick_q <= '0;
      ph_sec_q  <= '0;
      fr_run_q  <= 1'b0;
      fr_tick_q <= '0;
      fr_sec_q  <= '0;
      combo_q   <= '0;
      gst_q     <= '0;
      rel_q     <= '0;
      dots_q    <= '0;
      idle_q    <= '0;
      flash_q   <= 1'b0;
      sv_q      <= 1'b0;
      score_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      round_q   <= round_d;
      ph_tick_q <= ph_tick_d;
      ph_sec_q  <= ph_sec_d;
      fr_run_q  <= fr_run_d;
      fr_tick_q <= fr_tick_d;
      fr_sec_q  <= fr_sec_d;
      combo_q   <= combo_c;
      gst_q     <= gst_d;
      rel_q     <= rel_d;
      dots_q    <= dots_d;
      idle_q    <= idle_d;
      flash_q   <= flash_d;
      sv_q      <= sv_d;
      score_q   <= sum_c;
    end
  end

  assign global_mode  = mode_q;
  assign ghost_state  = gst_q;
  assign fright_flash = flash_q;
  assign released     = rel_q;
  assign round        = round_q;
  assign score_valid  = sv_q;
  assign score_value  = score_q;

endmodule
